// File: rtl/sj_sync_pkg.sv
// sj_sync_pkg
//   Shared definitions for the Taito SJ sync decoder: lock-tracker state
//   encoding, nominal raster dimensions and default counter widths.
package sj_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } lock_state_t;

  // Nominal Taito SJ raster
  localparam int unsigned H_TOTAL  = 384;
  localparam int unsigned H_ACTIVE = 256;
  localparam int unsigned V_TOTAL  = 264;

  // Length counter width; counters saturate at 2^CW-1
  localparam int unsigned CW_DEFAULT     = 10;
  // Consecutive matching measurements needed to declare lock
  localparam int unsigned LOCK_N_DEFAULT = 4;

endpackage

// File: rtl/sj_lock_fsm.sv
// sj_lock_fsm
//   Tracks a periodic length measurement and raises lock once LOCK_N
//   consecutive measurements agree.
//
//   clkm_48MHZ  system clock
//   RESET       asynchronous, active-high reset
//   meas        measurement presented with strobe (all-ones = saturated)
//   strobe      one-cycle measurement event
//   fault       one-cycle event: the measuring counter just saturated
//   lock        registered lock flag
module sj_lock_fsm
  import sj_sync_pkg::*;
#(
  parameter int unsigned CW     = CW_DEFAULT,
  parameter int unsigned LOCK_N = LOCK_N_DEFAULT
) (
  input  logic          clkm_48MHZ,
  input  logic          RESET,
  input  logic [CW-1:0] meas,
  input  logic          strobe,
  input  logic          fault,
  output logic          lock
);

  // Wide enough that match+1 never wraps before reaching LOCK_N
  localparam int unsigned    MW         = $clog2(LOCK_N + 2);
  localparam logic [MW-1:0]  MATCH_ONE  = MW'(1);
  localparam logic [MW-1:0]  MATCH_LOCK = MW'(LOCK_N);
  localparam logic [CW-1:0]  SAT        = '1;

  lock_state_t   state;
  logic [MW-1:0] match;
  logic [CW-1:0] ref_len;
  logic          meas_sat;
  logic          meas_eq;

  assign meas_sat = (meas == SAT);
  assign meas_eq  = !meas_sat && (meas == ref_len);

  // A measurement strobe takes precedence over a saturation fault; the two
  // cannot coincide from the top level but the ordering keeps it defined.
  always_ff @(posedge clkm_48MHZ or posedge RESET) begin
    if (RESET) begin
      state   <= SEARCH;
      match   <= '0;
      ref_len <= '0;
      lock    <= 1'b0;
    end else if (strobe) begin
      unique case (state)
        SEARCH: begin
          ref_len <= meas;
          match   <= MATCH_ONE;
          state   <= TRACK;
        end
        TRACK: begin
          if (meas_eq) begin
            match <= match + 1'b1;
            if ((match + 1'b1) == MATCH_LOCK) begin
              state <= LOCKED;
              lock  <= 1'b1;
            end
          end else begin
            ref_len <= meas;
            match   <= MATCH_ONE;
          end
        end
        LOCKED: begin
          if (!meas_eq) begin
            state <= SEARCH;
            match <= '0;
            lock  <= 1'b0;
          end
        end
        default: begin
          state <= SEARCH;
          match <= '0;
          lock  <= 1'b0;
        end
      endcase
    end else if (fault) begin
      state <= SEARCH;
      match <= '0;
      lock  <= 1'b0;
    end
  end

endmodule

// File: rtl/sj_sync_decoder.sv
// sj_sync_decoder
//   Recovers raster timing from the Taito SJ sync bus: active-pixel
//   coordinates, data enable, line/frame pulses, measured line and frame
//   lengths and lock status. All inputs are sampled on PIX_CE.
//
//   clkm_48MHZ   system clock          RESET        async, active-high
//   PIX_CE       pixel enable          HSYNC_IN/VSYNC_IN/HBL_IN/VBL_IN
//   X, Y         active column / line  DE           registered data enable
//   NEW_LINE     HSYNC rise pulse      NEW_FRAME    VSYNC rise pulse
//   LINE_LEN     last line length      FRAME_LINES  last frame length
//   H_LOCK, V_LOCK, LOCKED  lock flags (LOCKED = H_LOCK & V_LOCK)
module sj_sync_decoder #(
  parameter int unsigned LOCK_N = sj_sync_pkg::LOCK_N_DEFAULT,
  parameter int unsigned CW     = sj_sync_pkg::CW_DEFAULT
) (
  input  logic          clkm_48MHZ,
  input  logic          RESET,
  input  logic          PIX_CE,
  input  logic          HSYNC_IN,
  input  logic          VSYNC_IN,
  input  logic          HBL_IN,
  input  logic          VBL_IN,
  output logic [8:0]    X,
  output logic [8:0]    Y,
  output logic          DE,
  output logic          NEW_LINE,
  output logic          NEW_FRAME,
  output logic [CW-1:0] LINE_LEN,
  output logic [CW-1:0] FRAME_LINES,
  output logic          H_LOCK,
  output logic          V_LOCK,
  output logic          LOCKED
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_PRE = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          hs_q, vs_q, hb_q, vb_q;
  logic          hs_rise, vs_rise, hb_rise, hb_fall, vb_fall;
  logic [CW-1:0] hcnt, vcnt;
  logic          h_sat_evt, v_sat_evt;

  // Edge strobes already include PIX_CE so they are single-cycle events
  assign hs_rise = PIX_CE &  HSYNC_IN & ~hs_q;
  assign vs_rise = PIX_CE &  VSYNC_IN & ~vs_q;
  assign hb_rise = PIX_CE &  HBL_IN   & ~hb_q;
  assign hb_fall = PIX_CE & ~HBL_IN   &  hb_q;
  assign vb_fall = PIX_CE & ~VBL_IN   &  vb_q;

  // Fault when a counter is about to step onto its saturation value, so the
  // lock drop lands on the same edge at which the counter saturates.
  assign h_sat_evt = PIX_CE  & ~hs_rise & (hcnt == CNT_PRE);
  assign v_sat_evt = hs_rise & ~vs_rise & (vcnt == CNT_PRE);

  always_ff @(posedge clkm_48MHZ or posedge RESET) begin
    if (RESET) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hb_q        <= 1'b0;
      vb_q        <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      LINE_LEN    <= '0;
      FRAME_LINES <= '0;
      NEW_LINE    <= 1'b0;
      NEW_FRAME   <= 1'b0;
      X           <= '0;
      Y           <= '0;
      DE          <= 1'b0;
    end else begin
      NEW_LINE  <= hs_rise;
      NEW_FRAME <= vs_rise;
      if (PIX_CE) begin
        hs_q <= HSYNC_IN;
        vs_q <= VSYNC_IN;
        hb_q <= HBL_IN;
        vb_q <= VBL_IN;

        if (hs_rise) begin
          hcnt     <= CNT_ONE;
          LINE_LEN <= hcnt;
        end else if (hcnt != CNT_MAX) begin
          hcnt <= hcnt + 1'b1;
        end

        // VSYNC rise wins: a coincident line belongs to the new frame
        if (vs_rise) begin
          vcnt        <= CNT_ONE;
          FRAME_LINES <= vcnt;
        end else if (hs_rise && vcnt != CNT_MAX) begin
          vcnt <= vcnt + 1'b1;
        end

        if (hb_fall) begin
          X <= '0;
        end else if (!HBL_IN) begin
          X <= X + 1'b1;
        end

        if (vb_fall) begin
          Y <= '0;
        end else if (hb_rise && !VBL_IN) begin
          Y <= Y + 1'b1;
        end

        DE <= H_LOCK & V_LOCK & ~HBL_IN & ~VBL_IN;
      end
    end
  end

  sj_lock_fsm #(
    .CW     (CW),
    .LOCK_N (LOCK_N)
  ) u_h_lock (
    .clkm_48MHZ (clkm_48MHZ),
    .RESET      (RESET),
    .meas       (hcnt),
    .strobe     (hs_rise),
    .fault      (h_sat_evt),
    .lock       (H_LOCK)
  );

  sj_lock_fsm #(
    .CW     (CW),
    .LOCK_N (LOCK_N)
  ) u_v_lock (
    .clkm_48MHZ (clkm_48MHZ),
    .RESET      (RESET),
    .meas       (vcnt),
    .strobe     (vs_rise),
    .fault      (v_sat_evt),
    .lock       (V_LOCK)
  );

  assign LOCKED = H_LOCK & V_LOCK;

endmodule

// File: tb/tb_sj_sync_decoder.sv
// tb_sj_sync_decoder
//   Directed bench for sj_sync_decoder: nominal 384-pixel lines for the
//   horizontal lock sequence, a short-line 264-line raster for frame lock and
//   coordinate limits, async reset mid-line, and HSYNC loss / saturation.
module tb_sj_sync_decoder;

  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_ce;
  logic          hs, vs, hb, vb;
  logic [8:0]    x, y;
  logic          de, new_line, new_frame;
  logic [CW-1:0] line_len, frame_lines;
  logic          h_lock, v_lock, locked;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          gap   = 1;

  // Snapshots taken inside raster_line
  logic [31:0] c0_ll, c0_fl, c0_vcnt;
  logic        c0_nl, c0_nf, c0_nl_next, c0_nf_next, c0_hl, c0_vl, c0_lk, c0_de;
  logic [8:0]  ca_x, ca_y, cb_x, cb_y;
  logic        ca_de, cb_de;

  sj_sync_decoder #(
    .LOCK_N (4),
    .CW     (CW)
  ) dut (
    .clkm_48MHZ  (clk),
    .RESET       (rst),
    .PIX_CE      (pix_ce),
    .HSYNC_IN    (hs),
    .VSYNC_IN    (vs),
    .HBL_IN      (hb),
    .VBL_IN      (vb),
    .X           (x),
    .Y           (y),
    .DE          (de),
    .NEW_LINE    (new_line),
    .NEW_FRAME   (new_frame),
    .LINE_LEN    (line_len),
    .FRAME_LINES (frame_lines),
    .H_LOCK      (h_lock),
    .V_LOCK      (v_lock),
    .LOCKED      (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel: gap-1 idle clocks, then one PIX_CE clock; returns 1ns after
  // the PIX_CE edge so the outputs of that edge are visible.
  task automatic pix(input logic h, input logic v, input logic b, input logic vbl);
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
    hs = h; vs = v; hb = b; vb = vbl;
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
  endtask

  task automatic raster_line(input int len, input int hsw, input int hbw,
                             input logic v, input logic vbl, input int pa, input int pb);
    for (int p = 0; p < len; p++) begin
      pix(p < hsw, v, p < hbw, vbl);
      if (p == 0) begin
        c0_ll = 32'(line_len);  c0_fl = 32'(frame_lines);
        c0_vcnt = 32'(dut.vcnt);
        c0_nl = new_line;  c0_nf = new_frame;
        c0_hl = h_lock;    c0_vl = v_lock;  c0_lk = locked;  c0_de = de;
        @(posedge clk); #1;
        c0_nl_next = new_line;  c0_nf_next = new_frame;
      end
      if (p == pa) begin ca_x = x; ca_y = y; ca_de = de; end
      if (p == pb) begin cb_x = x; cb_y = y; cb_de = de; end
    end
  endtask

  task automatic nominal_line(input int len, input int pa, input int pb);
    raster_line(len, 33, int'(sj_sync_pkg::H_TOTAL - sj_sync_pkg::H_ACTIVE), 1'b0, 1'b0, pa, pb);
  endtask

  task automatic short_line(input int l, input int pa, input int pb);
    raster_line(16, 2, 4, l < 3, l < 8, pa, pb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_hl;
    logic seen;
    int   nl_cnt;

    rst = 1'b1; pix_ce = 1'b0; hs = 0; vs = 0; hb = 0; vb = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_x",        32'(x), 0);
    check_eq("rst_line_len", 32'(line_len), 0);
    check_eq("rst_h_lock",   32'(h_lock), 0);
    check_eq("rst_de",       32'(de), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal lines, PIX_CE every other clock
    gap = 2;
    repeat (5) pix(0, 0, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      nominal_line((k == 6) ? 383 : 384, (k == 5) ? 128 : -1, (k == 5) ? 383 : -1);
      case (k)
        1: begin
          check_eq("h1_line_len",   c0_ll, 5);
          check_eq("h1_new_line",   32'(c0_nl), 1);
          check_eq("h1_nl_next",    32'(c0_nl_next), 0);
          check_eq("h1_h_lock",     32'(c0_hl), 0);
        end
        2:  check_eq("h2_line_len", c0_ll, 384);
        4:  check_eq("h4_h_lock",   32'(c0_hl), 0);
        5: begin
          check_eq("h5_h_lock",     32'(c0_hl), 1);
          check_eq("h5_locked",     32'(c0_lk), 0);
          check_eq("h5_x_first",    32'(ca_x), 0);
          check_eq("h5_de_unlockv", 32'(ca_de), 0);
          check_eq("h5_x_last",     32'(cb_x), 255);
        end
        7: begin
          check_eq("short_line_len", c0_ll, 383);
          check_eq("short_h_lock",   32'(c0_hl), 0);
          check_eq("short_locked",   32'(c0_lk), 0);
          check_eq("short_de",       32'(c0_de), 0);
        end
        10: check_eq("relock3_h_lock", 32'(c0_hl), 0);
        11: check_eq("relock4_h_lock", 32'(c0_hl), 1);
        default: ;
      endcase
    end

    // Short-line 264-line raster; VSYNC and HSYNC always rise together
    gap = 1;
    for (int f = 1; f <= 6; f++) begin
      for (int l = 0; l < 264; l++) begin
        short_line(l, (f == 6 && l == 8) ? 4 : -1, (f == 6 && l == 263) ? 15 : -1);
        if (l == 0) begin
          case (f)
            1: begin
              check_eq("v1_frame_lines", c0_fl, 11);
              check_eq("v1_v_lock",      32'(c0_vl), 0);
            end
            2: begin
              check_eq("v2_frame_lines", c0_fl, 264);
              check_eq("v2_v_lock",      32'(c0_vl), 0);
            end
            4: check_eq("v4_v_lock", 32'(c0_vl), 0);
            5: begin
              check_eq("v5_v_lock",       32'(c0_vl), 1);
              check_eq("v5_locked",       32'(c0_lk), 1);
              check_eq("v5_frame_lines",  c0_fl, 264);
              check_eq("v5_vcnt",         c0_vcnt, 1);
              check_eq("v5_new_line",     32'(c0_nl), 1);
              check_eq("v5_new_frame",    32'(c0_nf), 1);
              check_eq("v5_nf_next",      32'(c0_nf_next), 0);
            end
            default: ;
          endcase
        end
      end
    end
    check_eq("first_act_x",  32'(ca_x), 0);
    check_eq("first_act_y",  32'(ca_y), 0);
    check_eq("first_act_de", 32'(ca_de), 1);
    check_eq("last_act_x",   32'(cb_x), 11);
    check_eq("last_act_y",   32'(cb_y), 255);
    check_eq("last_act_de",  32'(cb_de), 1);

    // Async reset mid-line while locked
    for (int l = 0; l < 10; l++) short_line(l, -1, -1);
    for (int p = 0; p < 8; p++) pix(p < 2, 1'b0, p < 4, 1'b0);
    check_eq("pre_rst_locked", 32'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_x",           32'(x), 0);
    check_eq("arst_y",           32'(y), 0);
    check_eq("arst_de",          32'(de), 0);
    check_eq("arst_line_len",    32'(line_len), 0);
    check_eq("arst_frame_lines", 32'(frame_lines), 0);
    check_eq("arst_h_lock",      32'(h_lock), 0);
    check_eq("arst_v_lock",      32'(v_lock), 0);
    check_eq("arst_locked",      32'(locked), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Lock sequence after reset repeats the first one
    gap = 2;
    repeat (5) pix(0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      nominal_line(384, -1, -1);
      case (k)
        1: check_eq("r1_line_len", c0_ll, 5);
        2: check_eq("r2_line_len", c0_ll, 384);
        4: check_eq("r4_h_lock",   32'(c0_hl), 0);
        5: begin
          check_eq("r5_h_lock",    32'(c0_hl), 1);
          check_eq("r5_v_lock",    32'(c0_vl), 0);
        end
        default: ;
      endcase
    end

    // HSYNC lost: counter saturates, lock drops on that edge, no line pulse
    gap = 1;
    seen = 1'b0;
    nl_cnt = 0;
    prev_hl = h_lock;
    for (int i = 0; i < 1100; i++) begin
      pix(0, 0, 1, 0);
      if (new_line) nl_cnt++;
      if (!seen && dut.hcnt == 10'h3FF) begin
        seen = 1'b1;
        check_eq("sat_h_lock",        32'(h_lock), 0);
        check_eq("sat_h_lock_before", 32'(prev_hl), 1);
      end
      prev_hl = h_lock;
    end
    check_eq("sat_reached",    32'(seen), 1);
    check_eq("sat_hcnt",       32'(dut.hcnt), 1023);
    check_eq("sat_no_newline", 32'(nl_cnt), 0);
    check_eq("sat_line_len",   32'(line_len), 384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
